// File: rtl/muxn_arb.sv
// CH-to-1 arbitrated mux with a one-deep registered output stage; 1-cycle latency, R drops while the held word is stalled by YR.
// Define MUXN_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module muxn_arb #(
  parameter int n  = 8,
  parameter int CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*n-1:0]   D,
  input  logic [CH-1:0]     V,
  output logic [CH-1:0]     R,
  output logic [n-1:0]      Y,
  output logic              YV,
  input  logic              YR,
  output logic [CH-1:0]     G
);

  logic          load_en;
  logic [CH-1:0] gnt;
  logic [n-1:0]  sel_d;

  function automatic logic [CH-1:0] lowest_onehot(input logic [CH-1:0] req);
    logic [CH-1:0] oh;
    oh = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  // The output register can accept a new word when empty or draining this cycle.
  assign load_en = !YV || YR;

`ifdef MUXN_ARB_RR_EN
  localparam int PW = $clog2(CH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [CH-1:0] hi_mask;
  logic [CH-1:0] req_hi;

  // Requests above ptr take precedence; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < CH; i++) begin
      hi_mask[i] = (i > int'(ptr));
    end
    req_hi = V & hi_mask;
    if (|req_hi) gnt = lowest_onehot(req_hi);
    else         gnt = lowest_onehot(V);
  end

  always_comb begin
    win = ptr;
    for (int i = 0; i < CH; i++) begin
      if (gnt[i]) win = PW'(i);
    end
  end
`else
  always_comb begin
    gnt = lowest_onehot(V);
  end
`endif

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt[i]) sel_d = D[i*n +: n];
    end
  end

  assign R = (rst_n && load_en) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y   <= '0;
      YV  <= 1'b0;
      G   <= '0;
`ifdef MUXN_ARB_RR_EN
      ptr <= PW'(CH - 1);
`endif
    end else if (load_en) begin
      if (|V) begin
        Y   <= sel_d;
        YV  <= 1'b1;
        G   <= gnt;
`ifdef MUXN_ARB_RR_EN
        ptr <= win;
`endif
      end else begin
        // Drained with nothing pending: Y keeps its last value.
        YV  <= 1'b0;
        G   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb (CH=4, n=8); follows MUXN_ARB_RR_EN like the design.
module tb_muxn_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] D;
  logic [3:0]  V;
  logic [3:0]  R;
  logic [7:0]  Y;
  logic        YV;
  logic        YR;
  logic [3:0]  G;

  int checks   = 0;
  int failures = 0;

  // Reference state: held-word queue plus last Y, valid and pointer.
  logic [11:0] sbq[$];
  logic        m_yv  = 1'b0;
  logic [7:0]  m_y   = 8'h00;
  int          m_ptr = 3;

  muxn_arb #(.n(8), .CH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .D    (D),
    .V    (V),
    .R    (R),
    .Y    (Y),
    .YV   (YV),
    .YR   (YR),
    .G    (G)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  logic [3:0]  mr;
  logic [11:0] head;
  int          w;
  int          c;
  logic        load;

  always @(negedge clk) begin
    load = !m_yv || YR;
    mr   = 4'b0000;
    w    = -1;
    if (rst_n && load && V != 4'b0000) begin
`ifdef MUXN_ARB_RR_EN
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (w < 0 && V[c]) w = c;
      end
`else
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && V[k]) w = k;
      end
`endif
      mr[w] = 1'b1;
    end

    check("R", {28'd0, R}, {28'd0, mr});
    check("YV", {31'd0, YV}, {31'd0, m_yv});
    if (m_yv && sbq.size() > 0) begin
      head = sbq[0];
      check("Y", {24'd0, Y}, {24'd0, head[11:4]});
      check("G", {28'd0, G}, {28'd0, head[3:0]});
    end else begin
      check("Y_hold", {24'd0, Y}, {24'd0, m_y});
      check("G_idle", {28'd0, G}, 32'd0);
    end

    if (!rst_n) begin
      m_yv  = 1'b0;
      m_y   = 8'h00;
      m_ptr = 3;
      sbq.delete();
    end else if (load) begin
      if (m_yv && sbq.size() > 0) void'(sbq.pop_front());
      if (w >= 0) begin
        sbq.push_back({D[w*8 +: 8], mr});
        m_y   = D[w*8 +: 8];
        m_yv  = 1'b1;
        m_ptr = w;
      end else begin
        m_yv = 1'b0;
      end
    end
  end

  task automatic apply(input logic r, input logic [3:0] v, input logic yr,
                       input logic [31:0] d, input int cyc);
    rst_n = r;
    V     = v;
    YR    = yr;
    D     = d;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all channels requesting: R must stay low.
    apply(1'b0, 4'b1111, 1'b1, 32'h13121110, 2);
    // Single request on channel 2.
    apply(1'b1, 4'b0100, 1'b1, 32'h00A50000, 1);
    apply(1'b1, 4'b0000, 1'b1, 32'h00A50000, 2);
    // All channels requesting continuously.
    apply(1'b1, 4'b1111, 1'b1, 32'h13121110, 6);
    apply(1'b1, 4'b0000, 1'b1, 32'h13121110, 1);
    // Backpressure on a held 8'h3C.
    apply(1'b1, 4'b0001, 1'b1, 32'h0000003C, 1);
    apply(1'b1, 4'b0011, 1'b0, 32'h0000553C, 5);
    apply(1'b1, 4'b0011, 1'b1, 32'h0000553C, 2);
    apply(1'b1, 4'b0000, 1'b1, 32'h0000553C, 1);
    // Channels 1 and 3 only.
    apply(1'b1, 4'b1010, 1'b1, 32'hD300C100, 3);
    apply(1'b1, 4'b0000, 1'b1, 32'hD300C100, 1);
    // Reset while 8'h77 is held, then channels 0 and 3 compete.
    apply(1'b1, 4'b0010, 1'b1, 32'h00007700, 1);
    apply(1'b0, 4'b1111, 1'b1, 32'h00007700, 1);
    apply(1'b1, 4'b1001, 1'b1, 32'h90000009, 2);
    apply(1'b1, 4'b0000, 1'b1, 32'h90000009, 1);
    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 80; i++) begin
      apply(($urandom_range(0, 24) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), $urandom, 1);
    end
    apply(1'b1, 4'b0000, 1'b1, 32'h0, 3);
    check("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muxn_arb.md
MUXN_ARB -- requirements
Module: muxn_arb

Interface
REQ-001 Parameter n, default 8: data bitwidth per channel (n >= 1).
REQ-002 Parameter CH, default 4: number of input channels (2 <= CH <= 16); PW = $clog2(CH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 D  input  CH*n  channel data, channel i on bits [i*n +: n].
REQ-006 V  input  CH  per-channel valid; V[i] high = D channel i offers a word.
REQ-007 R  output  CH  per-channel ready; combinational, at most one bit high.
REQ-008 Y  output  n  registered selected data.
REQ-009 YV  output  1  registered output valid.
REQ-010 YR  input  1  downstream ready.
REQ-011 G  output  CH  registered one-hot tag of the channel whose word is held in Y; all-zero when YV low.

Function
REQ-012 Transfer on channel i SHALL occur in a cycle where V[i] and R[i] are both high; output transfer SHALL occur when YV and YR are both high.
REQ-013 load_en SHALL be (!YV || YR); R SHALL be all-zero when load_en is low or V is all-zero.
REQ-014 When load_en is high and V is nonzero, exactly one R bit SHALL be high: the bit of the winning channel per REQ-016/REQ-017.
REQ-015 On an input transfer from channel i, next cycle Y SHALL equal D channel i, YV SHALL be 1, G SHALL be one-hot at bit i; latency input-to-output is exactly 1 cycle.
REQ-016 Arbitration SHALL search channels starting at (ptr+1) mod CH and ascending with wrap-around; first channel with V high wins.
REQ-017 ptr (PW bits) SHALL update to the winning index on every input transfer and hold otherwise.
REQ-018 When YV and YR are high and no V is high, next cycle YV SHALL be 0 and G all-zero; Y SHALL hold its last value.
REQ-019 When YV high and YR low, Y, G, YV, ptr SHALL hold and R SHALL be all-zero (no word dropped, no overwrite).
REQ-020 Simultaneous output transfer and input transfer in one cycle SHALL be supported: full throughput, one word per cycle.
REQ-021 Upstream SHALL hold D and V stable until its transfer; arbiter decisions SHALL be recomputed every cycle (no grant lock while R low).
REQ-022 For CH not a power of two, ptr SHALL never exceed CH-1; wrap from CH-1 SHALL go to 0.

Reset
REQ-023 While rst_n low at a clock edge: YV=0, Y=0, G=0, ptr=CH-1 (channel 0 has first priority after reset).
REQ-024 R SHALL be all-zero in any cycle rst_n is low, regardless of V or YR.
REQ-025 Reset asserted mid-operation SHALL discard the held word; no transfer completes in a reset cycle.

Configuration
REQ-026 Macro MUXN_ARB_RR_EN: when defined, arbitration SHALL be round-robin per REQ-016/REQ-017.
REQ-027 When MUXN_ARB_RR_EN is undefined, arbitration SHALL be fixed priority (lowest index with V high wins), ptr SHALL not exist, all other behaviour unchanged.

Verification
REQ-028 Reset: rst_n=0 one cycle, V=4'b1111, YR=1 -> R=0000 during reset; after: YV=0, Y=8'h00, G=0000.
REQ-029 Single channel: V=4'b0100, D ch2=8'hA5, YR=1 -> R=0100 same cycle; next cycle Y=8'hA5, YV=1, G=0100.
REQ-030 Round-robin (RR_EN defined): V=4'b1111 held, YR=1, D ch i = 8'h10+i -> Y sequence 10,11,12,13,10 on consecutive cycles, YV continuously 1.
REQ-031 Backpressure: word 8'h3C held with YV=1, YR=0 for 5 cycles, V=4'b0011 -> Y stays 8'h3C, R=0000 throughout; YR=1 -> next winner loads the following cycle.
REQ-032 Fixed priority (RR_EN undefined): V=4'b1010, YR=1 for 3 cycles -> G=0010 every cycle, channel 3 never granted.
REQ-033 Reset mid-stream: YV=1, Y=8'h77, assert rst_n=0 one cycle -> YV=0, G=0000; after release with V=4'b1001, channel 0 wins first.
